// File: rtl/pipe_stream_adapter.sv
// Valid/ready stream adapter for a fixed-latency, clken-gated pipe.
// Tracks in-flight tokens with a valid shift register and buffers results with credit-based flow control.
module pipe_stream_adapter #(
  parameter  int IN_WIDTH  = 8,
  parameter  int OUT_WIDTH = 8,
  parameter  int LATENCY   = 4,
  parameter  int DEPTH     = LATENCY + 2,
  localparam int LVL_W     = $clog2(DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 aresetn,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [IN_WIDTH-1:0]  s_data,
  output logic                 pipe_clken,
  output logic [IN_WIDTH-1:0]  pipe_data_in,
  input  logic [OUT_WIDTH-1:0] pipe_data_out,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [OUT_WIDTH-1:0] m_data,
  output logic [LVL_W-1:0]     level
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [LATENCY-1:0]   vld;
  logic [LVL_W-1:0]     inflight;
  logic [LVL_W-1:0]     count;
  logic [PTR_W-1:0]     rd_ptr;
  logic [PTR_W-1:0]     wr_ptr;
  logic [OUT_WIDTH-1:0] mem [DEPTH];

  logic [LVL_W:0] occupancy;
  logic           space_ok;
  logic           accept;
  logic           wr_en;
  logic           pop;

  function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // NOTE: credit comes from registered count/inflight only, so a same-cycle pop
  // never feeds back into s_ready; it frees the slot one cycle later.
  assign occupancy = {1'b0, count} + {1'b0, inflight};
  assign space_ok  = occupancy < (LVL_W + 1)'(DEPTH);

  assign s_ready      = aresetn && space_ok;
  assign accept       = s_valid && s_ready;
  assign pipe_clken   = accept || (inflight != '0);
  assign pipe_data_in = s_data;

  // The pipe result for the oldest in-flight token is valid alongside vld[LATENCY-1].
  assign wr_en   = pipe_clken && vld[LATENCY-1];
  assign m_valid = (count != '0);
  assign pop     = m_valid && m_ready;
  assign m_data  = mem[rd_ptr];
  assign level   = occupancy[LVL_W-1:0];

  // NOTE: sequential state uses non-blocking assignments so every stage of the
  // shift register samples the value from before the edge.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      vld      <= '0;
      inflight <= '0;
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
    end else begin
      if (pipe_clken) begin
        vld[0] <= accept;
        for (int i = 1; i < LATENCY; i++) begin
          vld[i] <= vld[i-1];
        end
      end
      inflight <= inflight + LVL_W'(accept) - LVL_W'(wr_en);
      count    <= count + LVL_W'(wr_en) - LVL_W'(pop);
      if (wr_en) wr_ptr <= bump(wr_ptr);
      if (pop)   rd_ptr <= bump(rd_ptr);
    end
  end

  // NOTE: FIFO storage has no reset; count gates m_valid, so stale entries are never observed.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= pipe_data_out;
  end

  assert property (@(posedge clk) disable iff (!aresetn) !(wr_en && (count == LVL_W'(DEPTH))))
    else $error("pipe_stream_adapter: write into full output FIFO");

endmodule

// File: tb/tb_pipe_stream_adapter.sv
// Randomized bench for pipe_stream_adapter with a 4-stage clken delay line as the attached pipe.
// A token-level scoreboard predicts ready, clken, valid, level and output data every cycle.
module tb_pipe_stream_adapter;

  localparam int IN_WIDTH  = 8;
  localparam int OUT_WIDTH = 8;
  localparam int LATENCY   = 4;
  localparam int DEPTH     = LATENCY + 2;
  localparam int LVL_W     = $clog2(DEPTH + 1);

  logic                 clk = 1'b0;
  logic                 aresetn = 1'b0;
  logic                 s_valid = 1'b0;
  logic                 s_ready;
  logic [IN_WIDTH-1:0]  s_data = '0;
  logic                 pipe_clken;
  logic [IN_WIDTH-1:0]  pipe_data_in;
  logic [OUT_WIDTH-1:0] pipe_data_out;
  logic                 m_valid;
  logic                 m_ready = 1'b0;
  logic [OUT_WIDTH-1:0] m_data;
  logic [LVL_W-1:0]     level;

  always #5 clk = ~clk;

  pipe_stream_adapter #(
    .IN_WIDTH (IN_WIDTH),
    .OUT_WIDTH(OUT_WIDTH),
    .LATENCY  (LATENCY),
    .DEPTH    (DEPTH)
  ) dut (
    .clk          (clk),
    .aresetn      (aresetn),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .s_data       (s_data),
    .pipe_clken   (pipe_clken),
    .pipe_data_in (pipe_data_in),
    .pipe_data_out(pipe_data_out),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .m_data       (m_data),
    .level        (level)
  );

  // Attached pipe: clken-gated identity delay line.
  logic [OUT_WIDTH-1:0] dly [LATENCY];
  always @(posedge clk) begin
    if (pipe_clken) begin
      dly[0] <= pipe_data_in;
      for (int i = 1; i < LATENCY; i++) dly[i] <= dly[i-1];
    end
  end
  assign pipe_data_out = dly[LATENCY-1];

  // Reference model: tokens in the pipe carry the edge at which they land in the FIFO.
  typedef struct {
    int                   due;
    logic [OUT_WIDTH-1:0] data;
  } tok_t;

  tok_t                 pipe_q[$];
  logic [OUT_WIDTH-1:0] fifo_q[$];
  int                   edge_n = 0;
  int                   checks = 0;
  int                   errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s @edge %0d: got %0h expected %0h", tag, edge_n, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [IN_WIDTH-1:0] d, input logic r);
    s_valid = v;
    s_data  = d;
    m_ready = r;
  endtask

  // Compare at the negedge, advance the model for the coming posedge, then leave inputs free at posedge+1.
  task automatic step();
    int   occ;
    logic acc;
    logic pop;
    @(negedge clk);
    occ = fifo_q.size() + pipe_q.size();
    acc = s_valid && (occ < DEPTH);
    pop = (fifo_q.size() != 0) && m_ready;
    check("s_ready", 32'(s_ready), 32'(occ < DEPTH));
    check("pipe_clken", 32'(pipe_clken), 32'(acc || (pipe_q.size() != 0)));
    check("pipe_data_in", 32'(pipe_data_in), 32'(s_data));
    check("m_valid", 32'(m_valid), 32'(fifo_q.size() != 0));
    check("level", 32'(level), 32'(occ));
    if (fifo_q.size() != 0) check("m_data", 32'(m_data), 32'(fifo_q[0]));
    if (pop) void'(fifo_q.pop_front());
    while (pipe_q.size() != 0 && pipe_q[0].due == edge_n) fifo_q.push_back(pipe_q.pop_front().data);
    if (acc) pipe_q.push_back('{due: edge_n + LATENCY, data: s_data});
    edge_n++;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input logic r);
    for (int i = 0; i < n; i++) begin
      drive(1'b0, 8'h00, r);
      step();
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_s_ready"}, 32'(s_ready), 32'd0);
    check({tag, "_pipe_clken"}, 32'(pipe_clken), 32'd0);
    check({tag, "_m_valid"}, 32'(m_valid), 32'd0);
    check({tag, "_level"}, 32'(level), 32'd0);
  endtask

  initial begin
    drive(1'b1, 8'hFF, 1'b1);
    #2;
    check_reset_outputs("reset");
    repeat (3) @(posedge clk);
    #1;
    aresetn = 1'b1;
    drive(1'b0, 8'h00, 1'b1);
    idle(2, 1'b1);

    // Single token through an otherwise idle adapter.
    drive(1'b1, 8'h5A, 1'b1);
    step();
    idle(8, 1'b1);

    // Back-to-back stream with the sink always ready.
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 8'(i), 1'b1);
      step();
    end
    idle(8, 1'b1);

    // Sink stalled: credit runs out at DEPTH, then drains in order.
    for (int i = 0; i < 12; i++) begin
      drive(1'b1, 8'(8'h30 + i), 1'b0);
      step();
    end
    check("stall_level", 32'(level), 32'(DEPTH));
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 8'(8'h40 + i), 1'b1);
      step();
    end
    idle(10, 1'b1);

    // Alternating valid: bubbles must keep the pipe moving but never reach the FIFO.
    for (int i = 0; i < 16; i++) begin
      drive(i % 2 == 0, 8'(8'hA0 + i / 2), 1'b1);
      step();
    end
    idle(8, 1'b1);

    // Random traffic on both sides.
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 3) != 0), 8'($urandom), 1'($urandom_range(0, 2) != 0));
      step();
    end
    idle(12, 1'b1);

    // Five tokens with the sink stalled, one idle cycle: 3 in flight and 2 buffered.
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 8'(8'hC0 + i), 1'b0);
      step();
    end
    idle(1, 1'b0);
    check("pre_reset_level", 32'(level), 32'd5);
    check("pre_reset_m_valid", 32'(m_valid), 32'd1);
    drive(1'b1, 8'hEE, 1'b1);
    aresetn = 1'b0;
    #1;
    check_reset_outputs("midreset");
    pipe_q.delete();
    fifo_q.delete();
    repeat (2) @(posedge clk);
    #1;
    aresetn = 1'b1;
    drive(1'b0, 8'h00, 1'b1);
    check("post_reset_level", 32'(level), 32'd0);
    idle(8, 1'b1);
    drive(1'b1, 8'h77, 1'b1);
    step();
    idle(8, 1'b1);

    for (int i = 0; i < 200; i++) begin
      drive(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 3) != 0));
      step();
    end

    // Long idle after drain.
    idle(30, 1'b1);
    check("idle_level", 32'(level), 32'd0);
    check("idle_pipe_clken", 32'(pipe_clken), 32'd0);
    check("idle_m_valid", 32'(m_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
